// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the register-exchange Viterbi decoder: state count, branch labels.
// Latency: none (constant functions and types only).
// Backpressure: not applicable.
package viterbi_pkg;

    // Default path-metric width; the decoder's PM_W parameter defaults to this.
    localparam int PM_W_DEF = 8;

    // Path metric at the default width.
    typedef logic [PM_W_DEF-1:0] pm_t;

    // Number of trellis states for constraint length k.
    function automatic int ns(input int k);
        return 1 << (k - 1);
    endfunction

    // Encoder output {c1,c0} when bit b enters with state s (newest bit in MSB of s).
    function automatic logic [1:0] enc_out(input int k, input int g0, input int g1,
                                           input int b, input int s);
        int r;
        r = (b << (k - 1)) | s;
        return {^(r & g1), ^(r & g0)};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state: picks the cheaper of its two predecessors.
// Latency: combinational.
// Backpressure: none; the caller decides when to commit the result.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    input  logic            vld0,
    input  logic            vld1,
    output logic            sel,
    output logic            vld,
    output logic [PM_W-1:0] pm_new
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0 = pm0 + PM_W'(bm0);
    assign cand1 = pm1 + PM_W'(bm1);

    // Ties and an unreachable p1 both fall back to p0; unreachable states carry metric 0.
    assign sel    = vld1 && (!vld0 || (cand1 < cand0));
    assign vld    = vld0 || vld1;
    assign pm_new = !vld ? '0 : (sel ? cand1 : cand0);

endmodule

// File: rtl/viterbi_re_decoder.sv
// Rate-1/2 hard-decision Viterbi decoder with register-exchange survivors; VITERBI_BEST_STATE_EN selects best-state decode.
// Latency: first out_valid one cycle after the (TB_DEPTH+1)th accepted symbol, then one bit per accept.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output holds the whole trellis.
module viterbi_re_decoder
    import viterbi_pkg::*;
#(
    parameter int             K        = 4,
    parameter logic [K-1:0]   G0       = 4'b1111,
    parameter logic [K-1:0]   G1       = 4'b1101,
    parameter int             PM_W     = PM_W_DEF,
    parameter int             TB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit
);

    localparam int NS = ns(K);
    localparam int SW = K - 1;
    localparam int FW = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm       [NS];
    logic [PM_W-1:0]     pm_acs   [NS];
    logic [PM_W-1:0]     pm_nxt   [NS];
    logic [TB_DEPTH-1:0] surv     [NS];
    logic [TB_DEPTH-1:0] surv_nxt [NS];
    logic [NS-1:0]       pm_vld;
    logic [NS-1:0]       vld_acs;
    logic [NS-1:0]       psel;
    logic [FW-1:0]       fill_cnt;
    logic [SW-1:0]       sel;
    logic                accept;
    logic                emit;
    logic                all_msb;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (fill_cnt == FW'(TB_DEPTH));

    // Target t is reached from {t[K-3:0],0} and {t[K-3:0],1} with input bit t[K-2].
    for (genvar t = 0; t < NS; t++) begin : g_state
        localparam int          P0 = (2 * t) % NS;
        localparam int          P1 = P0 + 1;
        localparam int          B  = t / (NS / 2);
        localparam logic [1:0]  E0 = enc_out(K, int'(G0), int'(G1), B, P0);
        localparam logic [1:0]  E1 = enc_out(K, int'(G0), int'(G1), B, P1);

        logic [1:0] d0;
        logic [1:0] d1;
        logic [1:0] bm0;
        logic [1:0] bm1;

        assign d0  = sym ^ E0;
        assign d1  = sym ^ E1;
        assign bm0 = {1'b0, d0[1]} + {1'b0, d0[0]};
        assign bm1 = {1'b0, d1[1]} + {1'b0, d1[0]};

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (pm[P0]),
            .pm1    (pm[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .vld0   (pm_vld[P0]),
            .vld1   (pm_vld[P1]),
            .sel    (psel[t]),
            .vld    (vld_acs[t]),
            .pm_new (pm_acs[t])
        );

        assign pm_nxt[t]   = all_msb ? {1'b0, pm_acs[t][PM_W-2:0]} : pm_acs[t];
        assign surv_nxt[t] = {(psel[t] ? surv[P1][TB_DEPTH-2:0] : surv[P0][TB_DEPTH-2:0]), 1'(B)};
    end

    // Rebase metrics once every reachable state has crossed the half-range mark.
    always_comb begin
        all_msb = 1'b1;
        for (int t = 0; t < NS; t++) begin
            if (vld_acs[t] && !pm_acs[t][PM_W-1]) begin
                all_msb = 1'b0;
            end
        end
    end

`ifdef VITERBI_BEST_STATE_EN
    logic [PM_W-1:0] best_pm;

    // Argmin over reachable pre-update metrics; state 0 is always reachable so it seeds the search.
    always_comb begin
        sel     = '0;
        best_pm = pm[0];
        for (int t = 1; t < NS; t++) begin
            if (pm_vld[t] && (pm[t] < best_pm)) begin
                sel     = SW'(t);
                best_pm = pm[t];
            end
        end
    end
`else
    assign sel = '0;
`endif

    // Trellis state: metrics, reachability, survivors and fill count advance only on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NS; t++) begin
                pm[t]   <= '0;
                surv[t] <= '0;
            end
            pm_vld   <= NS'(1);
            fill_cnt <= '0;
        end else if (clr) begin
            for (int t = 0; t < NS; t++) begin
                pm[t]   <= '0;
                surv[t] <= '0;
            end
            pm_vld   <= NS'(1);
            fill_cnt <= '0;
        end else if (accept) begin
            for (int t = 0; t < NS; t++) begin
                pm[t]   <= pm_nxt[t];
                surv[t] <= surv_nxt[t];
            end
            pm_vld <= vld_acs;
            if (fill_cnt != FW'(TB_DEPTH)) begin
                fill_cnt <= fill_cnt + FW'(1);
            end
        end
    end

    // Output holding register; a fresh decision wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_bit   <= surv[sel][TB_DEPTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_re_decoder.sv
// Directed bench for viterbi_re_decoder: zero stream, PRBS7 encode/decode, errors, stalls, restart.
// Latency: expects output = encoder input delayed by 16 symbols.
// Backpressure: exercises out_ready stalls and checks in_ready follows.
module tb_viterbi_re_decoder;

    localparam int         PM_W   = 8;
    localparam int         DEPTH  = 16;
    localparam logic [3:0] G0_REF = 4'b1111;
    localparam logic [3:0] G1_REF = 4'b1101;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sym;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic info_q[$];
    logic out_q[$];

    logic mon_pm    = 1'b0;
    int   max_min   = 0;
    int   norm_seen = 0;
    int   cur_min;

    always #5 clk = ~clk;

    viterbi_re_decoder #(
        .K        (4),
        .G0       (4'b1111),
        .G1       (4'b1101),
        .PM_W     (PM_W),
        .TB_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sym       (sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit)
    );

    // Collect every output handshake.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_q.push_back(out_bit);
        end
    end

    // Track the smallest reachable metric and count rebase events.
    always @(negedge clk) begin
        if (mon_pm) begin
            cur_min = 1 << PM_W;
            for (int t = 0; t < 8; t++) begin
                if (dut.pm_vld[t] && (int'(dut.pm[t]) < cur_min)) begin
                    cur_min = int'(dut.pm[t]);
                end
            end
            if (cur_min > max_min) max_min = cur_min;
            if (dut.accept && dut.all_msb) norm_seen++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] s);
        int n;
        n        = 0;
        sym      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check_eq("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    function automatic int seq_errs();
        int e;
        e = 0;
        for (int j = 0; j < out_q.size(); j++) begin
            if (j >= info_q.size() || out_q[j] !== info_q[j]) e++;
        end
        return e;
    endfunction

    // mode 0 clean, 1 one flip every 12 symbols, 2 three consecutive flips, 3 output stall.
    // stop_at >= 0 sends only that many symbols and leaves the stream un-drained.
    task automatic feed_prbs(input int n, input int mode, input int stop_at);
        logic [6:0] lfsr;
        logic [2:0] st;
        logic [3:0] r;
        logic [1:0] s;
        logic       b;
        int         lim;
        lfsr = 7'h7F;
        st   = '0;
        info_q.delete();
        out_q.delete();
        lim = (stop_at >= 0) ? stop_at : n;
        for (int i = 0; i < lim; i++) begin
            b    = lfsr[6] ^ lfsr[5];
            lfsr = {lfsr[5:0], b};
            info_q.push_back(b);
            r  = {b, st};
            s  = {^(r & G1_REF), ^(r & G0_REF)};
            st = {b, st[2:1]};
            if (mode == 1 && (i % 12) == 5) s[0] = ~s[0];
            if (mode == 2 && i >= 20 && i <= 22) s[0] = ~s[0];
            send(s);
            if (mode == 3 && i == DEPTH) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    check_eq("t5_in_ready_low", in_ready, 0);
                    check_eq("t5_out_valid_held", out_valid, 1);
                    check_eq("t5_out_bit_stable", out_bit, info_q[0]);
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (stop_at < 0) idle(3);
    endtask

    initial begin
        int ones;
        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        sym       = 2'b00;
        out_ready = 1'b0;
        #23;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_bit", out_bit, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // 1: all-zero stream
        out_q.delete();
        for (int i = 0; i < 40; i++) begin
            send(2'b00);
            if (i == DEPTH - 1) check_eq("t1_no_early_valid", out_valid, 0);
            if (i == DEPTH) check_eq("t1_first_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        idle(3);
        ones = 0;
        foreach (out_q[j]) if (out_q[j] !== 1'b0) ones++;
        check_eq("t1_count", out_q.size(), 24);
        check_eq("t1_nonzero_bits", ones, 0);

        // 2: clean PRBS7
        do_clr();
        feed_prbs(64, 0, -1);
        check_eq("t2_count", out_q.size(), 48);
        check_eq("t2_errs", seq_errs(), 0);

        // 3: sparse single flips, then a burst
        do_clr();
        feed_prbs(64, 1, -1);
        check_eq("t3_count", out_q.size(), 48);
        check_eq("t3_errs", seq_errs(), 0);
`ifdef VITERBI_BEST_STATE_EN
        do_clr();
        feed_prbs(64, 2, -1);
        check_eq("t3b_count", out_q.size(), 48);
        check_eq("t3b_errs_le16", (seq_errs() <= 16), 1);
`endif

        // 4: alternating 00/11 noise, metrics must rebase and never wrap
        do_clr();
        out_q.delete();
        max_min   = 0;
        norm_seen = 0;
        mon_pm    = 1'b1;
        for (int i = 0; i < 2000; i++) send((i % 2) ? 2'b11 : 2'b00);
        in_valid = 1'b0;
        idle(3);
        mon_pm = 1'b0;
        check_eq("t4_count", out_q.size(), 1984);
        check_eq("t4_min_pm_below_half", (max_min < (1 << (PM_W - 1))), 1);
        check_eq("t4_norm_seen", (norm_seen > 0), 1);

        // 5: output stall after first decision
        do_clr();
        feed_prbs(64, 3, -1);
        check_eq("t5_count", out_q.size(), 48);
        check_eq("t5_errs", seq_errs(), 0);

        // 6a: clr early in a stream, then a full clean run
        do_clr();
        feed_prbs(64, 0, 10);
        do_clr();
        feed_prbs(64, 0, -1);
        check_eq("t6a_count", out_q.size(), 48);
        check_eq("t6a_errs", seq_errs(), 0);

        // 6b: clr discards a pending output
        do_clr();
        feed_prbs(64, 0, 20);
        check_eq("t6b_pending", out_valid, 1);
        out_ready = 1'b0;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_eq("t6b_clr_drops_valid", out_valid, 0);
        out_ready = 1'b1;

        // 6c: async reset mid-stream, then a full clean run
        feed_prbs(64, 0, 30);
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6c_rst_out_valid", out_valid, 0);
        check_eq("t6c_rst_out_bit", out_bit, 0);
        check_eq("t6c_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        feed_prbs(64, 0, -1);
        check_eq("t6c_count", out_q.size(), 48);
        check_eq("t6c_errs", seq_errs(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
